// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the 32x64 integer register file slice.
//   DATA_W   : register width in bits
//   NUM_REGS : number of architectural registers (5-bit select fields)
//   SEL_W    : width of every register select field
//   ZERO_REG : index hardwired to zero (never written, never busy)
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;
  localparam int SEL_W    = 5;
  localparam int ZERO_REG = 31;

  typedef logic [SEL_W-1:0]  reg_sel_t;
  typedef logic [DATA_W-1:0] reg_word_t;

  // True when a select field addresses the hardwired zero register.
  function automatic logic is_zero_reg(input reg_sel_t sel);
    return (sel == reg_sel_t'(ZERO_REG));
  endfunction

endpackage : regfile_pkg

// File: rtl/reg_write_decoder.sv
// -----------------------------------------------------------------------------
// reg_write_decoder
// 5-to-32 one-hot decoder with an active-high enable. Used for both the
// register write strobes and the scoreboard busy-set strobes.
// Ports:
//   en     : input,  decode enable; all outputs low when 0
//   sel    : input,  index to decode
//   onehot : output, onehot[i] = en & (sel == i)
// -----------------------------------------------------------------------------
module reg_write_decoder
  import regfile_pkg::*;
(
  input  logic                en,
  input  logic [SEL_W-1:0]    sel,
  output logic [NUM_REGS-1:0] onehot
);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
    assign onehot[gi] = en & (sel == SEL_W'(gi));
  end

endmodule : reg_write_decoder

// File: rtl/reg_file_32x64.sv
// -----------------------------------------------------------------------------
// reg_file_32x64
// 32-entry x 64-bit integer register file with two combinational read ports,
// one write port and a per-register busy scoreboard. Sits between write-back
// (producer) and decode/operand fetch (consumer). Register ZERO_REG reads as
// zero, discards writes and is never busy.
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   wr_en/wr_sel/wr_data  : write-back port (also clears the busy bit)
//   rd_sel_a/rd_data_a    : read port A, combinational
//   rd_sel_b/rd_data_b    : read port B, combinational
//   mark_en/mark_sel      : issue marks a destination register busy
//   busy_a/busy_b         : selected operand still has a pending producer
//   stall                 : busy_a | busy_b
// -----------------------------------------------------------------------------
module reg_file_32x64
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [SEL_W-1:0]  rd_sel_a,
  input  logic [SEL_W-1:0]  rd_sel_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              mark_en,
  input  logic [SEL_W-1:0]  mark_sel,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall
);

  // ---------------------------------------------------------------------------
  // Strobe decode
  // ---------------------------------------------------------------------------
  logic [NUM_REGS-1:0] we;
  logic [NUM_REGS-1:0] mark;

  reg_write_decoder u_wr_dec (
    .en     (wr_en),
    .sel    (wr_sel),
    .onehot (we)
  );

  reg_write_decoder u_mark_dec (
    .en     (mark_en),
    .sel    (mark_sel),
    .onehot (mark)
  );

  // ---------------------------------------------------------------------------
  // Register array. The zero-register entry is never written, so it holds the
  // reset value forever; the read mux also forces it to zero explicitly.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_reg [NUM_REGS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we[i] && (i != ZERO_REG)) begin
          regs_reg[i] <= wr_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard. Clear-then-set ordering makes a same-index mark win over
  // a write-back: the mark belongs to a newer producer.
  // ---------------------------------------------------------------------------
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
    if (gi == ZERO_REG) begin : g_zero
      assign busy_next[gi] = 1'b0;
    end else begin : g_norm
      assign busy_next[gi] = (busy_reg[gi] & ~we[gi]) | mark[gi];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports. Priority: zero register, then same-cycle write forward, then
  // the stored value.
  // ---------------------------------------------------------------------------
  logic fwd_a;
  logic fwd_b;

  assign fwd_a = BYPASS && wr_en && (wr_sel == rd_sel_a);
  assign fwd_b = BYPASS && wr_en && (wr_sel == rd_sel_b);

  always_comb begin
    rd_data_a = regs_reg[rd_sel_a];
    if (rd_sel_a == SEL_W'(ZERO_REG)) begin
      rd_data_a = '0;
    end else if (fwd_a) begin
      rd_data_a = wr_data;
    end
  end

  always_comb begin
    rd_data_b = regs_reg[rd_sel_b];
    if (rd_sel_b == SEL_W'(ZERO_REG)) begin
      rd_data_b = '0;
    end else if (fwd_b) begin
      rd_data_b = wr_data;
    end
  end

  // A forwarded write satisfies the operand in the same cycle, so the reader
  // is not held up even though the busy bit only clears on the clock edge.
  assign busy_a = busy_reg[rd_sel_a] & ~fwd_a;
  assign busy_b = busy_reg[rd_sel_b] & ~fwd_b;
  assign stall  = busy_a | busy_b;

endmodule : reg_file_32x64

// File: tb/tb_reg_file_32x64.sv
// -----------------------------------------------------------------------------
// tb_reg_file_32x64
// Directed-vector bench for reg_file_32x64. Inputs change 1 ns after the
// rising edge; outputs are sampled a further 1 ns later.
// -----------------------------------------------------------------------------
module tb_reg_file_32x64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_sel = '0;
  logic [63:0] wr_data = '0;
  logic [4:0]  rd_sel_a = '0;
  logic [4:0]  rd_sel_b = '0;
  logic [63:0] rd_data_a;
  logic [63:0] rd_data_b;
  logic        mark_en = 1'b0;
  logic [4:0]  mark_sel = '0;
  logic        busy_a;
  logic        busy_b;
  logic        stall;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  reg_file_32x64 dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_sel_a  (rd_sel_a),
    .rd_sel_b  (rd_sel_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .mark_en   (mark_en),
    .mark_sel  (mark_sel),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .stall     (stall)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    mark_en = 1'b0;
  endtask

  // Sweep all indices on both ports expecting an empty file.
  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_sel_a = 5'(i);
      rd_sel_b = 5'(31 - i);
      #1;
      checks++;
      if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0 ||
          busy_a !== 1'b0 || busy_b !== 1'b0 || stall !== 1'b0)
        $display("FAIL %s idx=%0d: a=%h b=%h busy_a=%b busy_b=%b stall=%b, required all zero",
                 tag, i, rd_data_a, rd_data_b, busy_a, busy_b, stall);
      else passed++;
    end
    $display("sweep %s: 32 indices read on both ports", tag);
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #2;
    sweep_zero("during_reset");
    tick();
    reset = 1'b0;
    #1;
    sweep_zero("after_reset");
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_sel = 5'd5; wr_data = 64'hDEAD_BEEF_0123_4567;
    tick();
    wr_en = 1'b1; wr_sel = 5'd6; wr_data = 64'h0F0F_1234_8000_0001;
    rd_sel_a = 5'd5; rd_sel_b = 5'd0;
    #1;
    $display("write sel=5 then read a=5: got %h", rd_data_a);
    checks++;
    if (rd_data_a !== 64'hDEAD_BEEF_0123_4567)
      $display("FAIL write_read_5: got %h required %h", rd_data_a, 64'hDEAD_BEEF_0123_4567);
    else passed++;
    checks++;
    if (rd_data_b !== 64'h0)
      $display("FAIL untouched_reg0: got %h required 0", rd_data_b);
    else passed++;
    tick();
    idle();
    rd_sel_b = 5'd6;
    #1;
    $display("write sel=6 then read b=6: got %h", rd_data_b);
    checks++;
    if (rd_data_b !== 64'h0F0F_1234_8000_0001 || rd_data_a !== 64'hDEAD_BEEF_0123_4567)
      $display("FAIL write_read_6: a=%h b=%h required a=%h b=%h", rd_data_a, rd_data_b,
               64'hDEAD_BEEF_0123_4567, 64'h0F0F_1234_8000_0001);
    else passed++;
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_sel = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    rd_sel_b = 5'd31;
    #1;
    checks++;
    if (rd_data_b !== 64'h0)
      $display("FAIL zero_reg_same_cycle: got %h required 0", rd_data_b);
    else passed++;
    tick();
    idle();
    #1;
    $display("write all-ones to sel=31, read b=31: got %h", rd_data_b);
    checks++;
    if (rd_data_b !== 64'h0)
      $display("FAIL zero_reg_after_write: got %h required 0", rd_data_b);
    else passed++;
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_sel = 5'd7; wr_data = 64'h42;
    rd_sel_a = 5'd7; rd_sel_b = 5'd7;
    #1;
    $display("bypass write sel=7 data=42: a=%h b=%h busy_a=%b", rd_data_a, rd_data_b, busy_a);
    checks++;
    if (rd_data_a !== 64'h42 || rd_data_b !== 64'h42 || busy_a !== 1'b0)
      $display("FAIL bypass_same_cycle: a=%h b=%h busy_a=%b required 42 42 0",
               rd_data_a, rd_data_b, busy_a);
    else passed++;
    tick();
    // Overwrite reg 5 while port A reads it: forwarded value must win over stored.
    wr_en = 1'b1; wr_sel = 5'd5; wr_data = 64'h1111_2222_3333_4444;
    rd_sel_a = 5'd5; rd_sel_b = 5'd7;
    #1;
    checks++;
    if (rd_data_a !== 64'h1111_2222_3333_4444 || rd_data_b !== 64'h42)
      $display("FAIL bypass_overwrite: a=%h b=%h required %h 42",
               rd_data_a, rd_data_b, 64'h1111_2222_3333_4444);
    else passed++;
    tick();
    idle();
    #1;
    checks++;
    if (rd_data_a !== 64'h1111_2222_3333_4444)
      $display("FAIL overwrite_stored: got %h required %h", rd_data_a, 64'h1111_2222_3333_4444);
    else passed++;
  endtask

  task automatic test_scoreboard();
    mark_en = 1'b1; mark_sel = 5'd3;
    tick();
    idle();
    rd_sel_a = 5'd3; rd_sel_b = 5'd0;
    #1;
    $display("mark sel=3, read a=3: busy_a=%b stall=%b", busy_a, stall);
    checks++;
    if (busy_a !== 1'b1 || stall !== 1'b1 || busy_b !== 1'b0)
      $display("FAIL mark_busy: busy_a=%b busy_b=%b stall=%b required 1 0 1", busy_a, busy_b, stall);
    else passed++;
    // Same reg on port B too: both ports see busy independently.
    rd_sel_b = 5'd3;
    #1;
    checks++;
    if (busy_b !== 1'b1)
      $display("FAIL mark_busy_b: got %b required 1", busy_b);
    else passed++;
    rd_sel_b = 5'd0;
    wr_en = 1'b1; wr_sel = 5'd3; wr_data = 64'd9;
    #1;
    $display("write-back sel=3 data=9: busy_a=%b stall=%b a=%h", busy_a, stall, rd_data_a);
    checks++;
    if (busy_a !== 1'b0 || stall !== 1'b0 || rd_data_a !== 64'd9)
      $display("FAIL writeback_same_cycle: busy_a=%b stall=%b a=%h required 0 0 9",
               busy_a, stall, rd_data_a);
    else passed++;
    tick();
    idle();
    #1;
    checks++;
    if (busy_a !== 1'b0 || rd_data_a !== 64'd9)
      $display("FAIL writeback_cleared: busy_a=%b a=%h required 0 9", busy_a, rd_data_a);
    else passed++;
    // Different indices in one cycle: both mark and clear land.
    mark_en = 1'b1; mark_sel = 5'd11;
    tick();
    mark_en = 1'b1; mark_sel = 5'd12;
    wr_en = 1'b1; wr_sel = 5'd11; wr_data = 64'hABC;
    tick();
    idle();
    rd_sel_a = 5'd12; rd_sel_b = 5'd11;
    #1;
    $display("mark 12 + write 11: busy_a(12)=%b busy_b(11)=%b", busy_a, busy_b);
    checks++;
    if (busy_a !== 1'b1 || busy_b !== 1'b0 || rd_data_b !== 64'hABC)
      $display("FAIL split_mark_write: busy12=%b busy11=%b r11=%h required 1 0 abc",
               busy_a, busy_b, rd_data_b);
    else passed++;
    // Writing a reg that is not busy leaves it not busy.
    wr_en = 1'b1; wr_sel = 5'd13; wr_data = 64'h5;
    tick();
    idle();
    rd_sel_a = 5'd13;
    #1;
    checks++;
    if (busy_a !== 1'b0 || rd_data_a !== 64'h5)
      $display("FAIL write_not_busy: busy=%b data=%h required 0 5", busy_a, rd_data_a);
    else passed++;
  endtask

  task automatic test_collision();
    mark_en = 1'b1; mark_sel = 5'd10;
    wr_en = 1'b1; wr_sel = 5'd10; wr_data = 64'h77;
    tick();
    idle();
    rd_sel_a = 5'd10; rd_sel_b = 5'd0;
    #1;
    $display("mark+write sel=10: busy_a=%b stall=%b a=%h", busy_a, stall, rd_data_a);
    checks++;
    if (busy_a !== 1'b1 || stall !== 1'b1 || rd_data_a !== 64'h77)
      $display("FAIL mark_wins: busy_a=%b stall=%b a=%h required 1 1 77", busy_a, stall, rd_data_a);
    else passed++;
    // Re-mark an already busy register: stays busy.
    mark_en = 1'b1; mark_sel = 5'd10;
    tick();
    idle();
    #1;
    checks++;
    if (busy_a !== 1'b1)
      $display("FAIL remark_busy: got %b required 1", busy_a);
    else passed++;
    mark_en = 1'b1; mark_sel = 5'd31;
    tick();
    idle();
    rd_sel_a = 5'd31;
    #1;
    $display("mark sel=31, read a=31: busy_a=%b", busy_a);
    checks++;
    if (busy_a !== 1'b0 || rd_data_a !== 64'h0)
      $display("FAIL zero_never_busy: busy_a=%b a=%h required 0 0", busy_a, rd_data_a);
    else passed++;
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_sel = 5'(i); wr_data = 64'h100 + 64'(i);
      tick();
    end
    idle();
    mark_en = 1'b1; mark_sel = 5'd2;
    tick();
    idle();
    rd_sel_a = 5'd2; rd_sel_b = 5'd4;
    #1;
    checks++;
    if (busy_a !== 1'b1 || rd_data_b !== 64'h104 || rd_data_a !== 64'h102)
      $display("FAIL pre_reset_state: busy2=%b r2=%h r4=%h required 1 102 104",
               busy_a, rd_data_a, rd_data_b);
    else passed++;
    // Mid-cycle reset with a write and a mark that must both be lost.
    #1;
    wr_en = 1'b1; wr_sel = 5'd1; wr_data = 64'hBAD;
    mark_en = 1'b1; mark_sel = 5'd1;
    reset = 1'b1;
    #1;
    $display("async reset mid-cycle at %0t: r2=%h r4=%h busy_a=%b", $time, rd_data_a, rd_data_b, busy_a);
    checks++;
    if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0 || busy_a !== 1'b0 || stall !== 1'b0)
      $display("FAIL async_reset_immediate: r2=%h r4=%h busy_a=%b stall=%b required all 0",
               rd_data_a, rd_data_b, busy_a, stall);
    else passed++;
    tick();
    idle();
    reset = 1'b0;
    #1;
    sweep_zero("after_async_reset");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_collision();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule : tb_reg_file_32x64
